// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
//   Shared types and helpers for the bit-serial adder controller.
//   - state_t    : controller state encoding (IDLE, RUN, DONE), 2 bits
//   - cnt_width(): bit-position counter width derived from the operand width
// ----------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must index bit positions 0..w-1; keep at least one bit so the
    // declaration stays legal for the smallest operand widths.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl_if
//   Producer/consumer handshake bundle for the bit-serial adder.
//   Input side : in_valid, in_ready, a, b, cin
//   Output side: out_valid, out_ready, sum, cout
//   Modports   : slave  - the adder controller
//                master - the environment (producer + consumer)
// ----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/full_add_cell.sv
// ----------------------------------------------------------------------------
// full_add_cell
//   Purely combinational 1-bit full adder, time-shared by the controller.
//   Ports: a, b, cin (inputs) -> s (sum bit), c (carry out)
// ----------------------------------------------------------------------------
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);
    logic p;

    // Propagate term shared by sum and carry.
    assign p = a ^ b;
    assign s = p ^ cin;
    assign c = (a & b) | (p & cin);
endmodule

// File: rtl/serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in by
//   running one full_add_cell LSB-first over WIDTH clock cycles, keeping the
//   carry in a flop between bits.
//   Ports:
//     clk   - single clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - serial_add_ctrl_if.slave: in_valid/in_ready/a/b/cin from the
//             producer, out_valid/out_ready/sum/cout to the consumer
//   Result {cout,sum} = a + b + cin; out_valid rises WIDTH cycles after the
//   accepting edge and holds until out_ready.
// ----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_add_ctrl_if.slave    bus
);
    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cell_s;
    logic             cell_c;

    full_add_cell u_cell (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q),
        .s   (cell_s),
        .c   (cell_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand shifters, result shifter, carry flop and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so that after WIDTH shifts
                    // the first (LSB) cell output lands in sum_q[0].
                    sum_q   <= {cell_s, sum_q[WIDTH-1:1]};
                    a_q     <= {1'b0, a_q[WIDTH-1:1]};
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    carry_q <= cell_c;
                    // Saturate at the last bit position; the next accept
                    // clears it, so no wrap is ever visible.
                    if (cnt_q != LAST) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl (WIDTH=8) and full_add_cell.
//   A negedge scoreboard models the adder as "accept -> a+b+cin appears
//   WIDTH cycles later, held until taken"; directed tables and sequences cover
//   the carry, backpressure, reset and back-to-back corners.
// ----------------------------------------------------------------------------
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic ca, cb, cc, cs, cco;
    full_add_cell u_cell_tb (
        .a   (ca),
        .b   (cb),
        .cin (cc),
        .s   (cs),
        .c   (cco)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic             pending = 1'b0;
    logic [WIDTH:0]   exp_val = '0;
    int               acc_cyc = 0;
    int               acc_times[$];

    always @(negedge rst_n) pending = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("mon_in_ready", 32'(bus.in_ready), 32'(!pending));
            chk("mon_out_valid", 32'(bus.out_valid), 32'(pending && (cyc - acc_cyc >= WIDTH)));
            if (bus.out_valid && pending) begin
                chk("mon_result", 32'({bus.cout, bus.sum}), 32'(exp_val));
                if (bus.out_ready) pending = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                pending = 1'b1;
                exp_val = (WIDTH+1)'(bus.a) + (WIDTH+1)'(bus.b) + (WIDTH+1)'(bus.cin);
                acc_cyc = cyc + 1;
                acc_times.push_back(cyc + 1);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < WIDTH + 4) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                          input logic tc, input logic [WIDTH-1:0] es, input logic ec,
                          input string nm);
        int lat;
        chk({nm, "_in_ready_pre"}, 32'(bus.in_ready), 32'd1);
        bus.a = ta; bus.b = tbv; bus.cin = tc;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        // Operands may change freely once accepted.
        bus.in_valid = 1'b0;
        bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
        wait_out(lat);
        chk({nm, "_latency"}, 32'(lat), 32'(WIDTH));
        chk({nm, "_sum"}, 32'(bus.sum), 32'(es));
        chk({nm, "_cout"}, 32'(bus.cout), 32'(ec));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({nm, "_in_ready_post"}, 32'(bus.in_ready), 32'd1);
        chk({nm, "_out_valid_post"}, 32'(bus.out_valid), 32'd0);
        chk({nm, "_sum_kept"}, 32'(bus.sum), 32'(es));
    endtask

    typedef struct {
        logic a, b, cin;
        logic s, c;
    } cell_vec_t;

    typedef struct {
        logic [WIDTH-1:0] a, b;
        logic             cin;
        logic [WIDTH-1:0] s;
        logic             co;
        string            nm;
    } op_vec_t;

    cell_vec_t cell_tab[8];
    op_vec_t   op_tab[6];

    initial begin
        int lat;
        int n;

        cell_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cell_tab[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        cell_tab[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        cell_tab[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        cell_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        cell_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        cell_tab[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        cell_tab[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        op_tab[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "op_7f_01"};
        op_tab[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "op_ff_01"};
        op_tab[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "op_a5_5a_c"};
        op_tab[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "op_zero"};
        op_tab[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "op_max"};
        op_tab[5] = '{8'h3C, 8'h81, 1'b1, 8'hBE, 1'b0, "op_3c_81_c"};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        ca = 1'b0; cb = 1'b0; cc = 1'b0;

        // Cell truth table
        for (int i = 0; i < 8; i++) begin
            ca = cell_tab[i].a; cb = cell_tab[i].b; cc = cell_tab[i].cin;
            #1;
            chk($sformatf("cell_s_%0d", i), 32'(cs), 32'(cell_tab[i].s));
            chk($sformatf("cell_c_%0d", i), 32'(cco), 32'(cell_tab[i].c));
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed operand table
        for (int i = 0; i < 6; i++) begin
            run_op(op_tab[i].a, op_tab[i].b, op_tab[i].cin, op_tab[i].s, op_tab[i].co, op_tab[i].nm);
        end

        // Backpressure: result held, second request ignored until IDLE
        bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("bp_latency", 32'(lat), 32'(WIDTH));
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.a = 8'hFF; bus.b = 8'h00; bus.cin = 1'b0;
            #1;
            chk("bp_sum_hold", 32'(bus.sum), 32'h46);
            chk("bp_cout_hold", 32'(bus.cout), 32'd0);
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_idle_sum_kept", 32'(bus.sum), 32'h46);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_second_accepted", 32'(bus.in_ready), 32'd0);
        wait_out(lat);
        chk("bp_second_latency", 32'(lat), 32'(WIDTH));
        chk("bp_second_sum", 32'(bus.sum), 32'hFF);
        chk("bp_second_cout", 32'(bus.cout), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Asynchronous reset during the third RUN cycle
        bus.a = 8'h33; bus.b = 8'h44; bus.cin = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum", 32'(bus.sum), 32'd0);
        chk("mid_rst_cout", 32'(bus.cout), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, "post_rst");

        // Back-to-back with in_valid held high; operands scrambled every cycle
        acc_times.delete();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        n = 0;
        while (acc_times.size() < 3 && n < 100) begin
            bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_times.size()), 32'd3);
        if (acc_times.size() >= 3) begin
            chk("b2b_gap1", 32'(acc_times[1] - acc_times[0]), 32'(WIDTH + 2));
            chk("b2b_gap2", 32'(acc_times[2] - acc_times[1]), 32'(WIDTH + 2));
        end
        n = 0;
        while (pending && n < 3 * WIDTH) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_drain", 32'(pending), 32'd0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        n = 0;
        while (pending && n < 3 * WIDTH) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rand_drain", 32'(pending), 32'd0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got t=%0t want finish earlier", $time);
        $fatal(1, "timeout");
    end
endmodule
